// File: rtl/uart_cmd_rx.sv
// UART 8N1 receiver with A5/addr/data-hi/data-lo/checksum command-frame parser.
// Optional inter-byte timeout is enabled by defining UART_CMD_TIMEOUT_EN.
module uart_cmd_rx #(
    parameter int         CLKS_PER_BIT = 868,
    parameter logic [7:0] HDR_BYTE     = 8'hA5,
    parameter int         TIMEOUT_CLKS = 1000000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_uart_rx,
    output logic [7:0]  o_byte,
    output logic        o_byte_valid,
    output logic        o_cmd_valid,
    output logic [7:0]  o_cmd_addr,
    output logic [15:0] o_cmd_data,
    output logic        o_frame_err,
    output logic        o_chk_err
);
    localparam int             CW      = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0]  HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]  BIT_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {P_HDR, P_ADDR, P_DHI, P_DLO, P_CHK} p_state_t;

    generate
        if (CLKS_PER_BIT < 4 || TIMEOUT_CLKS < 1) begin : g_param_check
            $error("uart_cmd_rx: CLKS_PER_BIT must be >= 4 and TIMEOUT_CLKS >= 1");
        end
    endgenerate

    function automatic logic [7:0] frame_chk(input logic [7:0] a, input logic [7:0] h,
                                             input logic [7:0] l);
        return a ^ h ^ l;
    endfunction

    logic          sync1_r, sync2_r, rx_s, armed_r;
    logic [1:0]    settle_r;
    rx_state_t     rx_state_r, rx_next_s;
    p_state_t      p_state_r, p_next_s;
    logic [CW-1:0] clk_cnt_r;
    logic [2:0]    bit_cnt_r;
    logic [7:0]    shift_r, addr_r, dhi_r, dlo_r;
    logic          half_tick_s, bit_tick_s, good_byte_s, frame_err_s;
    logic          cmd_ok_s, chk_err_s, timeout_s;

    assign rx_s        = sync2_r;
    assign half_tick_s = (clk_cnt_r == HALF_M1);
    assign bit_tick_s  = (clk_cnt_r == BIT_M1);

    // Input synchronizer; settle_r marks when sync2_r reflects the real line after reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1_r  <= 1'b1;
            sync2_r  <= 1'b1;
            settle_r <= 2'b00;
        end else begin
            sync1_r  <= i_uart_rx;
            sync2_r  <= sync1_r;
            settle_r <= {settle_r[0], 1'b1};
        end
    end

    // Start detection is armed only once the line has been seen idle-high
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            armed_r <= 1'b0;
        end else if ((rx_state_r == RX_IDLE) && armed_r && !rx_s) begin
            armed_r <= 1'b0;
        end else if (frame_err_s) begin
            armed_r <= 1'b0;
        end else if (settle_r[1] && rx_s) begin
            armed_r <= 1'b1;
        end else begin
            armed_r <= armed_r;
        end
    end

    // Receiver state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_state_r <= RX_IDLE;
        end else begin
            rx_state_r <= rx_next_s;
        end
    end

    // Receiver next-state and end-of-byte strobes
    always_comb begin
        rx_next_s   = rx_state_r;
        good_byte_s = 1'b0;
        frame_err_s = 1'b0;
        case (rx_state_r)
            RX_IDLE: begin
                if (armed_r && !rx_s) rx_next_s = RX_START;
                else                  rx_next_s = RX_IDLE;
            end
            RX_START: begin
                if (half_tick_s) rx_next_s = rx_s ? RX_IDLE : RX_DATA;
                else             rx_next_s = RX_START;
            end
            RX_DATA: begin
                if (bit_tick_s && (bit_cnt_r == 3'd7)) rx_next_s = RX_STOP;
                else                                   rx_next_s = RX_DATA;
            end
            RX_STOP: begin
                if (bit_tick_s) begin
                    rx_next_s   = RX_IDLE;
                    good_byte_s = rx_s;
                    frame_err_s = !rx_s;
                end else begin
                    rx_next_s = RX_STOP;
                end
            end
            default: rx_next_s = RX_IDLE;
        endcase
    end

    // Bit timing counters and LSB-first shift register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            clk_cnt_r <= '0;
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'h00;
        end else begin
            case (rx_state_r)
                RX_IDLE: begin
                    clk_cnt_r <= '0;
                    bit_cnt_r <= 3'd0;
                end
                RX_START: clk_cnt_r <= half_tick_s ? '0 : clk_cnt_r + CNT_ONE;
                RX_DATA: begin
                    if (bit_tick_s) begin
                        clk_cnt_r <= '0;
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                        shift_r   <= {rx_s, shift_r[7:1]};
                    end else begin
                        clk_cnt_r <= clk_cnt_r + CNT_ONE;
                    end
                end
                RX_STOP: clk_cnt_r <= bit_tick_s ? '0 : clk_cnt_r + CNT_ONE;
                default: clk_cnt_r <= '0;
            endcase
        end
    end

`ifdef UART_CMD_TIMEOUT_EN
    localparam int            TW      = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TW-1:0] TMO_LIM = TW'(TIMEOUT_CLKS);
    logic [TW-1:0] tmo_cnt_r;

    assign timeout_s = (tmo_cnt_r == TMO_LIM);

    // Inter-byte timer runs only while a frame is partially received
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tmo_cnt_r <= '0;
        end else if (good_byte_s || (p_state_r == P_HDR)) begin
            tmo_cnt_r <= '0;
        end else if (!timeout_s) begin
            tmo_cnt_r <= tmo_cnt_r + TW'(1);
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Parser state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            p_state_r <= P_HDR;
        end else begin
            p_state_r <= p_next_s;
        end
    end

    // Parser next-state and checksum verdict; a framing error always resyncs
    always_comb begin
        p_next_s  = p_state_r;
        cmd_ok_s  = 1'b0;
        chk_err_s = 1'b0;
        if (frame_err_s) begin
            p_next_s = P_HDR;
        end else if (good_byte_s) begin
            case (p_state_r)
                P_HDR:  p_next_s = (shift_r == HDR_BYTE) ? P_ADDR : P_HDR;
                P_ADDR: p_next_s = P_DHI;
                P_DHI:  p_next_s = P_DLO;
                P_DLO:  p_next_s = P_CHK;
                P_CHK: begin
                    p_next_s = P_HDR;
                    if (shift_r == frame_chk(addr_r, dhi_r, dlo_r)) cmd_ok_s = 1'b1;
                    else                                            chk_err_s = 1'b1;
                end
                default: p_next_s = P_HDR;
            endcase
        end else if (timeout_s) begin
            p_next_s = P_HDR;
        end else begin
            p_next_s = p_state_r;
        end
    end

    // Frame field holding registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            addr_r <= 8'h00;
            dhi_r  <= 8'h00;
            dlo_r  <= 8'h00;
        end else if (good_byte_s) begin
            case (p_state_r)
                P_ADDR:  addr_r <= shift_r;
                P_DHI:   dhi_r  <= shift_r;
                P_DLO:   dlo_r  <= shift_r;
                default: addr_r <= addr_r;
            endcase
        end else begin
            addr_r <= addr_r;
        end
    end

    // Registered outputs; cmd pulse lines up with the checksum byte's byte pulse
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_byte       <= 8'h00;
            o_byte_valid <= 1'b0;
            o_cmd_valid  <= 1'b0;
            o_cmd_addr   <= 8'h00;
            o_cmd_data   <= 16'h0000;
            o_frame_err  <= 1'b0;
            o_chk_err    <= 1'b0;
        end else begin
            o_byte_valid <= good_byte_s;
            o_cmd_valid  <= cmd_ok_s;
            o_frame_err  <= frame_err_s;
            o_chk_err    <= chk_err_s;
            if (good_byte_s) o_byte <= shift_r;
            if (cmd_ok_s) begin
                o_cmd_addr <= addr_r;
                o_cmd_data <= {dhi_r, dlo_r};
            end
        end
    end
endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed self-checking bench for uart_cmd_rx at a short bit period (16 clocks/bit).
// Timeout scenario runs only when UART_CMD_TIMEOUT_EN is defined.
module tb_uart_cmd_rx;
    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic [7:0]  o_byte;
    logic        o_byte_valid, o_cmd_valid, o_frame_err, o_chk_err;
    logic [7:0]  o_cmd_addr;
    logic [15:0] o_cmd_data;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_byte = 0, n_cmd = 0, n_ferr = 0, n_cerr = 0, n_long = 0;
    int valid_cyc = 0;
    logic [7:0] last_byte = 8'h00;
    logic prev_bv = 1'b0, prev_cv = 1'b0, prev_fe = 1'b0, prev_ce = 1'b0;
    int b_byte, b_cmd, b_ferr, b_cerr, t0;

    uart_cmd_rx #(.CLKS_PER_BIT(CPB), .HDR_BYTE(8'hA5), .TIMEOUT_CLKS(20000)) dut (
        .i_clk(clk), .i_rst(rst), .i_uart_rx(rx),
        .o_byte(o_byte), .o_byte_valid(o_byte_valid), .o_cmd_valid(o_cmd_valid),
        .o_cmd_addr(o_cmd_addr), .o_cmd_data(o_cmd_data),
        .o_frame_err(o_frame_err), .o_chk_err(o_chk_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor sampled on the falling edge
    always @(negedge clk) begin
        if (o_byte_valid) begin
            n_byte++;
            last_byte = o_byte;
            valid_cyc = cyc;
        end
        if (o_cmd_valid) n_cmd++;
        if (o_frame_err) n_ferr++;
        if (o_chk_err)   n_cerr++;
        if ((o_byte_valid && prev_bv) || (o_cmd_valid && prev_cv) ||
            (o_frame_err && prev_fe) || (o_chk_err && prev_ce)) n_long++;
        prev_bv = o_byte_valid;
        prev_cv = o_cmd_valid;
        prev_fe = o_frame_err;
        prev_ce = o_chk_err;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] h,
                              input logic [7:0] l, input logic [7:0] c);
        send_byte(8'hA5, 1'b1);
        send_byte(a, 1'b1);
        send_byte(h, 1'b1);
        send_byte(l, 1'b1);
        send_byte(c, 1'b1);
    endtask

    task automatic mark();
        b_byte = n_byte;
        b_cmd  = n_cmd;
        b_ferr = n_ferr;
        b_cerr = n_cerr;
    endtask

    initial begin
        // Reset state
        repeat (5) @(negedge clk);
        chk("rst_byte", {24'h0, o_byte}, 32'h0);
        chk("rst_pulses", {28'h0, o_byte_valid, o_cmd_valid, o_frame_err, o_chk_err}, 32'h0);
        chk("rst_cmd", {8'h0, o_cmd_addr, o_cmd_data}, 32'h0);
        rst = 1'b0;
        idle_bits(2);

        // Single byte with latency window around 9.5 bit-times
        mark();
        t0 = cyc;
        send_byte(8'h3C, 1'b1);
        idle_bits(1);
        chk("single_byte", {24'h0, last_byte}, 32'h3C);
        chk("single_cnt", n_byte - b_byte, 1);
        chk("single_lat", ((valid_cyc - t0) >= 145 && (valid_cyc - t0) <= 165) ? 1 : 0, 1);
        chk("single_noerr", (n_ferr - b_ferr) + (n_cerr - b_cerr) + (n_cmd - b_cmd), 0);

        // Good frame back-to-back
        mark();
        send_frame(8'h01, 8'h00, 8'hAF, 8'hAE);
        idle_bits(1);
        chk("frA_cmd", n_cmd - b_cmd, 1);
        chk("frA_bytes", n_byte - b_byte, 5);
        chk("frA_addr", {24'h0, o_cmd_addr}, 32'h01);
        chk("frA_data", {16'h0, o_cmd_data}, 32'h00AF);

        // Bad checksum, then a correct frame
        mark();
        send_frame(8'h01, 8'h00, 8'hAF, 8'hAF);
        idle_bits(1);
        chk("bad_chkerr", n_cerr - b_cerr, 1);
        chk("bad_nocmd", n_cmd - b_cmd, 0);
        chk("bad_hold", {8'h0, o_cmd_addr, o_cmd_data}, 32'h000100AF);
        mark();
        send_frame(8'h07, 8'hBE, 8'hEF, 8'h56);
        idle_bits(1);
        chk("after_bad_cmd", n_cmd - b_cmd, 1);
        chk("after_bad_val", {8'h0, o_cmd_addr, o_cmd_data}, 32'h0007BEEF);

        // Framing error mid-frame resyncs the parser
        mark();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h55, 1'b0);
        idle_bits(2);
        chk("ferr_pulse", n_ferr - b_ferr, 1);
        chk("ferr_bytes", n_byte - b_byte, 2);
        mark();
        send_frame(8'h02, 8'h12, 8'h34, 8'h24);
        idle_bits(1);
        chk("resync_cmd", n_cmd - b_cmd, 1);
        chk("resync_noerr", n_cerr - b_cerr, 0);
        chk("resync_val", {8'h0, o_cmd_addr, o_cmd_data}, 32'h00021234);

        // Short low glitch on idle line
        mark();
        rx = 1'b0;
        repeat (5) @(negedge clk);
        idle_bits(3);
        chk("glitch", (n_byte - b_byte) + (n_ferr - b_ferr), 0);

        // Reset while a data byte is in flight with the line low
        send_byte(8'hA5, 1'b1);
        send_byte(8'h09, 1'b1);
        mark();
        rx = 1'b0;
        repeat (4 * CPB) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        idle_bits(3);
        chk("rst_mid_nopulse", (n_byte - b_byte) + (n_ferr - b_ferr) +
                               (n_cmd - b_cmd) + (n_cerr - b_cerr), 0);
        chk("rst_mid_clear", {8'h0, o_cmd_addr, o_cmd_data}, 32'h0);
        mark();
        send_frame(8'h0A, 8'h56, 8'h78, 8'h24);
        idle_bits(1);
        chk("post_rst_cmd", n_cmd - b_cmd, 1);
        chk("post_rst_val", {8'h0, o_cmd_addr, o_cmd_data}, 32'h000A5678);

`ifdef UART_CMD_TIMEOUT_EN
        // Inter-byte timeout discards a stalled frame
        mark();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h03, 1'b1);
        repeat (25000) @(negedge clk);
        send_byte(8'h00, 1'b1);
        send_byte(8'h10, 1'b1);
        send_byte(8'h13, 1'b1);
        idle_bits(1);
        chk("tmo_nocmd", (n_cmd - b_cmd) + (n_cerr - b_cerr), 0);
        mark();
        send_frame(8'h03, 8'h00, 8'h10, 8'h13);
        idle_bits(1);
        chk("tmo_after_cmd", n_cmd - b_cmd, 1);
        chk("tmo_after_val", {8'h0, o_cmd_addr, o_cmd_data}, 32'h00030010);
`endif

        chk("pulse_width", n_long, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_cmd_rx.md
Name: uart_cmd_rx

Overview:
- UART 8N1 receiver plus command-frame parser. It is the receive-side counterpart of the existing telemetry UART transmitter.
- Lets a host PC write controller registers (setpoint, kp, ki, kd) over a serial line.
- Sits between the board RX pin and the top level's setpoint/gain registers.
- Emits one write strobe per good frame, carrying an address and 16-bit data.

Parameters:
- CLKS_PER_BIT, 868, system clocks per UART bit (100 MHz / 115200 baud); must be >= 4.
- HDR_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CLKS, 1000000, inter-byte timeout in clocks; used only with UART_CMD_TIMEOUT_EN.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous reset, active-high
- i_uart_rx  in  1  asynchronous serial input, idle high
- o_byte  out  8  last received data byte
- o_byte_valid  out  1  one-cycle pulse: o_byte updated
- o_cmd_valid  out  1  one-cycle pulse: o_cmd_addr/o_cmd_data valid
- o_cmd_addr  out  8  register address of accepted frame
- o_cmd_data  out  16  register data of accepted frame
- o_frame_err  out  1  one-cycle pulse: stop bit sampled low
- o_chk_err  out  1  one-cycle pulse: frame checksum mismatch

Behaviour:
- Reset: all outputs 0; both FSMs idle; bit counter and clock counter 0; sync chain preset to 1.
- Input conditioning: 2-flop synchronizer on i_uart_rx. All decoding uses the second flop.
- Receiver FSM states: RX_IDLE, RX_START, RX_DATA, RX_STOP.
  - RX_IDLE → RX_START on a synchronized falling edge (value 0).
  - RX_START: wait CLKS_PER_BIT/2 clocks (integer divide), then sample the line. If the sample is 1 it is a glitch → RX_IDLE. If 0 → RX_DATA with the counter cleared.
  - RX_DATA: sample every CLKS_PER_BIT clocks, LSB first, 8 bits → RX_STOP.
  - RX_STOP: sample after CLKS_PER_BIT clocks.
    - Sample 1: o_byte loads the shift register and o_byte_valid pulses in the next cycle.
    - Sample 0: o_frame_err pulses, the byte is dropped, and the parser forces P_HDR.
  - Either way RX_STOP → RX_IDLE the same cycle. A new start bit may be detected immediately, so back-to-back bytes with no idle gap are supported.
- Parser FSM (advances only on an internal good-byte strobe): P_HDR, P_ADDR, P_DHI, P_DLO, P_CHK.
  - P_HDR: stay until byte == HDR_BYTE.
  - P_ADDR, P_DHI, P_DLO: capture each byte into a holding register.
  - P_CHK: expected value = addr ^ dhi ^ dlo.
    - Match: o_cmd_addr/o_cmd_data load from the holding registers and o_cmd_valid pulses one cycle, aligned with o_byte_valid of the checksum byte.
    - Mismatch: o_chk_err pulses and outputs are unchanged.
    - Both cases → P_HDR.
  - An HDR_BYTE value received in P_ADDR..P_CHK is treated as data, with no resync.
- o_cmd_addr/o_cmd_data hold their value until the next accepted frame.
- Output pulses are never longer than one cycle. At most one of o_cmd_valid/o_chk_err per frame.
- i_rst asserted mid-byte or mid-frame: the partial byte and partial frame are discarded with no pulses. The line must go idle-high and then low again before a new start is detected.
- Line held low permanently: one frame error per 10 bit-times at most. No o_byte_valid.

Optional Feature:
- Macro UART_CMD_TIMEOUT_EN.
- Defined:
  - A counter clears on each good byte and increments while the parser is not in P_HDR.
  - Reaching TIMEOUT_CLKS forces P_HDR, discards the partial frame, and issues no error pulse.
- Undefined: no counter; the parser waits indefinitely between bytes.

Test Plan:
- Single byte 8'h3C at 115200 baud (CLKS_PER_BIT=868) → o_byte=8'h3C, one o_byte_valid pulse about 9.5 bit-times after the start edge, no error pulses.
- Frame A5 01 00 AF AE (addr 01, data 00AF, chk 01^00^AF=AE) sent back-to-back → single o_cmd_valid, o_cmd_addr=8'h01, o_cmd_data=16'h00AF.
- Same frame with chk 8'hAF → o_chk_err pulse, no o_cmd_valid, outputs retain the previous value. A following correct frame is accepted.
- Byte 8'h55 with stop bit forced low, sent after A5 02 → o_frame_err pulse, parser in P_HDR. Then a full valid frame A5 02 12 34 24 → o_cmd_addr=02, o_cmd_data=1234.
- 0.3-bit low glitch on an idle line → no o_byte_valid, no o_frame_err. i_rst pulsed during the DHI byte of a frame → no pulses for that frame, and the next full frame is accepted.
- UART_CMD_TIMEOUT_EN with TIMEOUT_CLKS=20000: send A5 03, wait 25000 clocks, send 00 10 13 → no o_cmd_valid. Then send A5 03 00 10 13 → o_cmd_valid with data 16'h0010.
